// File: rtl/alice_dma_slot_arbiter_if.sv
// rtl/alice_dma_slot_arbiter_if.sv - DMA request / slot grant bundle for the Alice slot arbiter
interface alice_dma_slot_arbiter_if;
    logic       dsk_req;
    logic [3:0] aud_req;
    logic       cop_req;
    logic       blt_req;
    logic       cpu_req;
    logic [3:0] owner;
    logic [2:0] sub;
    logic       cpu_wait;

    modport master (
        output dsk_req, aud_req, cop_req, blt_req, cpu_req,
        input  owner, sub, cpu_wait
    );

    modport slave (
        input  dsk_req, aud_req, cop_req, blt_req, cpu_req,
        output owner, sub, cpu_wait
    );
endinterface

// File: rtl/alice_dma_slot_arbiter.sv
// rtl/alice_dma_slot_arbiter.sv - per-CCK chip-bus slot scheduler for the Alice display/DMA core
module alice_dma_slot_arbiter #(
    parameter int            HW        = 8,
    parameter logic [HW-1:0] HMAX      = HW'(8'hE2),
    parameter logic [HW-1:0] SPR_FIRST = HW'(8'h15)
) (
    input  logic          main_clk,
    input  logic          main_rst,
    input  logic          cck_rise,
    input  logic [HW-1:0] hctr,
    input  logic          vblank,
    input  logic [10:0]   dmacon,
    input  logic [HW-1:0] ddfstrt,
    input  logic [HW-1:0] ddfstop,
    input  logic [2:0]    nplanes,
    alice_dma_slot_arbiter_if.slave bus
);

    typedef enum logic [3:0] {
        OWN_IDLE = 4'd0,
        OWN_REF  = 4'd1,
        OWN_DSK  = 4'd2,
        OWN_AUD  = 4'd3,
        OWN_BPL  = 4'd4,
        OWN_SPR  = 4'd5,
        OWN_COP  = 4'd6,
        OWN_BLT  = 4'd7,
        OWN_CPU  = 4'd8
    } owner_e;

    typedef enum logic [1:0] {
        F_IDLE  = 2'd0,
        F_FETCH = 2'd1,
        F_FLUSH = 2'd2
    } fetch_e;

    localparam int BLTPRI = 10;
    localparam int DMAEN  = 9;
    localparam int BPLEN  = 8;
    localparam int COPEN  = 7;
    localparam int BLTEN  = 6;
    localparam int SPREN  = 5;
    localparam int DSKEN  = 4;

    fetch_e        fetch_q, fetch_d;
    logic [2:0]    flush_cnt_q, flush_cnt_d;
    owner_e        owner_q, win;
    logic [2:0]    sub_q, win_sub;
    logic          cpu_wait_q;
    logic [1:0]    blt_run_q, blt_run_d;

    logic [HW-1:0] strt_al, stop_al, spr_off;
    logic          dma_en, free_slot;
    logic          ref_slot, dsk_slot, aud_slot, spr_slot;
    logic [1:0]    aud_ch;
    logic [2:0]    fetch_phase, plane, np_eff;
    logic          bpl_ok, blt_ok, blt_yield;

    assign strt_al = ddfstrt & ~HW'(7);
    assign stop_al = ddfstop & ~HW'(7);
    assign dma_en  = dmacon[DMAEN];

    // Slots past the end of the line carry no fixed or fetch traffic.
    assign free_slot = hctr > HMAX;
    assign ref_slot  = (hctr <= HW'(7)) && hctr[0];
    assign dsk_slot  = (hctr >= HW'(9)) && (hctr <= HW'(13)) && hctr[0];
    assign aud_slot  = (hctr >= HW'(15)) && (hctr <= HW'(21)) && hctr[0];
    assign aud_ch    = hctr[2:1] + 2'd1;
    assign spr_off   = hctr - SPR_FIRST;
    assign spr_slot  = (hctr >= SPR_FIRST) && (spr_off < HW'(32)) && !spr_off[0];

    assign fetch_phase = hctr[2:0] - strt_al[2:0];
    assign np_eff      = (nplanes == 3'd7) ? 3'd6 : nplanes;

    always_comb begin
        plane = 3'd0;
        case (fetch_phase)
            3'd1:    plane = 3'd4;
            3'd2:    plane = 3'd6;
            3'd3:    plane = 3'd2;
            3'd5:    plane = 3'd3;
            3'd6:    plane = 3'd5;
            3'd7:    plane = 3'd1;
            default: plane = 3'd0;
        endcase
    end

    assign bpl_ok = (fetch_q != F_IDLE) && dma_en && dmacon[BPLEN] && !vblank &&
                    (plane != 3'd0) && (plane <= np_eff);

    assign blt_ok    = dma_en && dmacon[BLTEN] && bus.blt_req;
    // After three back-to-back blitter grants against a waiting CPU, the CPU gets one slot.
    assign blt_yield = bus.cpu_req && !dmacon[BLTPRI] && (blt_run_q == 2'd3);

    // Fetch window sequencer
    always_comb begin
        fetch_d     = fetch_q;
        flush_cnt_d = flush_cnt_q;
        if (cck_rise) begin
            case (fetch_q)
                F_IDLE: begin
                    if ((hctr == strt_al) && !vblank && (strt_al < stop_al))
                        fetch_d = F_FETCH;
                end
                F_FETCH: begin
                    if (hctr == stop_al) begin
                        fetch_d     = F_FLUSH;
                        flush_cnt_d = 3'd0;
                    end
                end
                F_FLUSH: begin
                    // Entered on the stop slot; the last flush slot is stop+7.
                    flush_cnt_d = flush_cnt_q + 3'd1;
                    if (flush_cnt_q == 3'd6)
                        fetch_d = F_IDLE;
                end
                default: fetch_d = F_IDLE;
            endcase
            if (hctr == HMAX)
                fetch_d = F_IDLE;
        end
    end

    always_ff @(posedge main_clk or posedge main_rst) begin
        if (main_rst) begin
            fetch_q     <= F_IDLE;
            flush_cnt_q <= 3'd0;
        end else begin
            fetch_q     <= fetch_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    // Slot owner selection, highest priority first
    always_comb begin
        win     = OWN_IDLE;
        win_sub = 3'd0;
        if (!free_slot && ref_slot) begin
            win     = OWN_REF;
            win_sub = {1'b0, hctr[2:1]};
        end else if (!free_slot && dsk_slot && dma_en && dmacon[DSKEN] && bus.dsk_req) begin
            win     = OWN_DSK;
        end else if (!free_slot && aud_slot && dma_en && dmacon[aud_ch] && bus.aud_req[aud_ch]) begin
            win     = OWN_AUD;
            win_sub = {1'b0, aud_ch};
        end else if (!free_slot && bpl_ok) begin
            win     = OWN_BPL;
            win_sub = plane - 3'd1;
        end else if (!free_slot && spr_slot && dma_en && dmacon[SPREN]) begin
            win     = OWN_SPR;
            win_sub = spr_off[4:2];
        end else if (!hctr[0] && dma_en && dmacon[COPEN] && bus.cop_req) begin
            win     = OWN_COP;
        end else if (blt_ok && !blt_yield) begin
            win     = OWN_BLT;
        end else if (bus.cpu_req) begin
            win     = OWN_CPU;
        end
    end

    always_comb begin
        blt_run_d = 2'd0;
        if ((win == OWN_BLT) && bus.cpu_req)
            blt_run_d = (blt_run_q == 2'd3) ? 2'd3 : blt_run_q + 2'd1;
    end

    always_ff @(posedge main_clk or posedge main_rst) begin
        if (main_rst) begin
            owner_q    <= OWN_IDLE;
            sub_q      <= 3'd0;
            cpu_wait_q <= 1'b0;
            blt_run_q  <= 2'd0;
        end else if (cck_rise) begin
            owner_q    <= win;
            sub_q      <= win_sub;
            cpu_wait_q <= bus.cpu_req && (win != OWN_CPU);
            blt_run_q  <= blt_run_d;
        end
    end

    assign bus.owner    = owner_q;
    assign bus.sub      = sub_q;
    assign bus.cpu_wait = cpu_wait_q;

endmodule
